forward_select_unit: RTL and testbench
======================================

Name: forward_select_unit

Overview:
- Generates the 2-bit operand-select codes that drive the EX-stage 4:1 operand muxes (sources: register file, EX/MEM, MEM/WB) of the 5-stage pipeline CPU.
- Tracks the destinations of in-flight instructions in internal pipeline tag registers.
- Detects load-use hazards, stalls ID for one cycle and inserts a bubble.
- Counts stall cycles for performance measurement.

Parameters:
- REG_ADDR_W, 5, register-address width.
- CNT_W, 32, stall counter width.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- id_valid_i  input  1  ID holds a real instruction.
- id_rs_i  input  REG_ADDR_W  ID source A register address.
- id_rt_i  input  REG_ADDR_W  ID source B register address.
- id_use_rs_i  input  1  ID instruction reads rs.
- id_use_rt_i  input  1  ID instruction reads rt.
- id_dest_i  input  REG_ADDR_W  ID resolved destination register.
- id_reg_write_i  input  1  ID instruction writes the register file.
- id_mem_read_i  input  1  ID instruction is a load.
- flush_i  input  1  taken branch/jump; ID instruction is discarded.
- fwd_a_sel_o  output  2  operand A mux select for the instruction in EX.
- fwd_b_sel_o  output  2  operand B mux select for the instruction in EX.
- stall_o  output  1  hold PC and IF/ID, bubble EX.
- stall_cnt_o  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Select encoding:
  - 00 = register file.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB write-back data.
  - 11 = reserved, never driven.
- Register file is write-before-read, so WB-to-ID needs no forwarding.
- Internal tags: ex_{dest,rw,mr}, mem_{dest,rw}. Reset clears all tags, selects = 00, stall_o = 0, stall_cnt_o = 0.
- Hazard (combinational):
  - Condition: id_valid_i && !flush_i && ex_mr && ex_dest != 0 && ((id_use_rs_i && ex_dest == id_rs_i) || (id_use_rt_i && ex_dest == id_rt_i)).
  - stall_o = hazard.
- Tag pipeline, every edge:
  - mem <= ex.
  - ex <= bubble (rw = 0, mr = 0, dest = 0) if stall_o, flush_i or !id_valid_i; otherwise ex <= id fields.
- Select registers: each edge, registered so they align with the instruction entering EX. Per operand X in {rs, rt}:
  - stall_o or flush_i or !id_valid_i -> 00.
  - else if ex_rw && ex_dest != 0 && ex_dest == id_X -> 01. Newest producer wins.
  - else if mem_rw && mem_dest != 0 && mem_dest == id_X -> 10.
  - else 00.
- After a load-use stall: the load sits in mem, so the held ID instruction gets 10 on the next edge. Select 01 is never produced for a load.
- Register 0: never forwarded, never causes a stall.
- Stall latency: stall_o lasts exactly one cycle per load-use pair, since the load leaves ex after one edge.
- stall_cnt_o: increments on each edge where stall_o = 1; saturates at all-ones.
- flush_i and hazard in the same cycle: flush wins, no stall, no count.
- Reset mid-stall: next cycle stall_o = 0, tags empty, counter 0.

Decomposition:
- Shared CPU package holds:
  - Select constants FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - REG_ADDR_W.
  - A tag struct {dest, rw, mr}.
- One natural sub-module, fwd_tag_pipe: the bubble-insertable ex/mem tag shift register.
- Compare/priority logic and the counter stay in the top module.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 (back-to-back) -> cycle the sub enters EX: fwd_a_sel_o = 01, fwd_b_sel_o = 00, stall_o = 0.
- add $3 ; nop ; or $6,$7,$3 -> fwd_b_sel_o = 10 when the or enters EX.
- add $3 then add $3 then and $8,$3,$3 -> both selects = 01 (newest wins, not 10).
- lw $2,0($1) then add $4,$2,$2 -> stall_o = 1 for exactly 1 cycle, EX receives bubble (selects 00), next edge both selects = 10, stall_cnt_o goes 0 -> 1.
- lw $0 / add $0 producers followed by a reader of $0 -> selects 00, no stall. Load-use pair with flush_i = 1 in the hazard cycle -> stall_o = 0, count unchanged.
- Assert rst_i during the stall cycle -> next cycle all outputs 0. Preload the counter path to all-ones and force a stall -> stall_cnt_o holds all-ones.

Source files
------------

// File: rtl/forward_select_unit_pkg.sv
// Shared CPU definitions used by the EX-stage forwarding logic:
// operand-select codes, register-address width and the in-flight destination tag.
package forward_select_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  rw;
    logic                  mr;
  } fwd_tag_t;

  localparam fwd_tag_t TAG_EMPTY = '{dest: {REG_ADDR_W{1'b0}}, rw: 1'b0, mr: 1'b0};

endpackage

// File: rtl/forward_select_unit_fwd_tag_pipe.sv
// Destination-tag shift register mirroring the ID->EX->MEM path; a bubble
// replaces the instruction entering EX while the one already in EX moves on.
module fwd_tag_pipe
  import forward_select_unit_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     bubble_i,
  input  fwd_tag_t id_tag_i,
  output fwd_tag_t ex_tag_o,
  output fwd_tag_t mem_tag_o
);

  fwd_tag_t ex_tag_r;
  fwd_tag_t mem_tag_r;

  // Advance tags one stage per edge, injecting an empty tag into EX on a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_tag_r  <= TAG_EMPTY;
      mem_tag_r <= TAG_EMPTY;
    end else begin
      mem_tag_r <= ex_tag_r;
      ex_tag_r  <= bubble_i ? TAG_EMPTY : id_tag_i;
    end
  end

  assign ex_tag_o  = ex_tag_r;
  assign mem_tag_o = mem_tag_r;

endmodule

// File: rtl/forward_select_unit.sv
// EX-stage operand forwarding select generation with load-use stall detection
// and a saturating stall-cycle counter.
module forward_select_unit #(
  parameter int REG_ADDR_W = forward_select_unit_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_use_rs_i,
  input  logic                  id_use_rt_i,
  input  logic [REG_ADDR_W-1:0] id_dest_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  flush_i,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  import forward_select_unit_pkg::*;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};

  fwd_tag_t         id_tag_s;
  fwd_tag_t         ex_tag_s;
  fwd_tag_t         mem_tag_s;
  logic             hazard_s;
  logic             bubble_s;
  logic [1:0]       sel_a_s;
  logic [1:0]       sel_b_s;
  logic [1:0]       sel_a_r;
  logic [1:0]       sel_b_r;
  logic [CNT_W-1:0] stall_cnt_r;

  // Newest producer wins; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] pick_sel(input logic [REG_ADDR_W-1:0] src,
                                          input fwd_tag_t ex_t,
                                          input fwd_tag_t mem_t);
    logic [1:0] sel;
    if (ex_t.rw && (ex_t.dest != REG_ZERO) && (ex_t.dest == src)) begin
      sel = FWD_EXMEM;
    end else if (mem_t.rw && (mem_t.dest != REG_ZERO) && (mem_t.dest == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  assign id_tag_s = '{dest: id_dest_i, rw: id_reg_write_i, mr: id_mem_read_i};

  // Load in EX feeding the ID instruction: its data only exists after MEM.
  always_comb begin
    hazard_s = 1'b0;
    if (id_valid_i && !flush_i && ex_tag_s.mr && (ex_tag_s.dest != REG_ZERO)) begin
      hazard_s = (id_use_rs_i && (ex_tag_s.dest == id_rs_i)) ||
                 (id_use_rt_i && (ex_tag_s.dest == id_rt_i));
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign bubble_s = hazard_s | flush_i | ~id_valid_i;

  fwd_tag_pipe u_tag_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bubble_i  (bubble_s),
    .id_tag_i  (id_tag_s),
    .ex_tag_o  (ex_tag_s),
    .mem_tag_o (mem_tag_s)
  );

  // Next operand selects for the instruction about to enter EX.
  always_comb begin
    sel_a_s = FWD_RF;
    sel_b_s = FWD_RF;
    if (bubble_s) begin
      sel_a_s = FWD_RF;
      sel_b_s = FWD_RF;
    end else begin
      sel_a_s = pick_sel(id_rs_i, ex_tag_s, mem_tag_s);
      sel_b_s = pick_sel(id_rt_i, ex_tag_s, mem_tag_s);
    end
  end

  // Select registers and saturating stall counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_a_r     <= FWD_RF;
      sel_b_r     <= FWD_RF;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      sel_a_r <= sel_a_s;
      sel_b_r <= sel_b_s;
      if (hazard_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
    end
  end

  assign fwd_a_sel_o = sel_a_r;
  assign fwd_b_sel_o = sel_b_r;
  assign stall_o     = hazard_s;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_forward_select_unit.sv
// Directed-vector bench for forward_select_unit; a second instance with a
// 2-bit counter exercises saturation.
module tb_forward_select_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_dest;
  logic       id_rw;
  logic       id_mr;
  logic       flush;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       stall;
  logic [31:0] cnt;
  logic [1:0] sat_sel_a;
  logic [1:0] sat_sel_b;
  logic       sat_stall;
  logic [1:0] sat_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  forward_select_unit dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dest_i(id_dest),
    .id_reg_write_i(id_rw), .id_mem_read_i(id_mr), .flush_i(flush),
    .fwd_a_sel_o(sel_a), .fwd_b_sel_o(sel_b), .stall_o(stall), .stall_cnt_o(cnt)
  );

  forward_select_unit #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dest_i(id_dest),
    .id_reg_write_i(id_rw), .id_mem_read_i(id_mr), .flush_i(flush),
    .fwd_a_sel_o(sat_sel_a), .fwd_b_sel_o(sat_sel_b), .stall_o(sat_stall), .stall_cnt_o(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one instruction in ID; inputs settle before any check.
  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] d,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dest = d; id_rw = rw; id_mr = mr; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    nop();
    tick(); tick();
    check_val("rst_sel_a", {30'd0, sel_a}, 32'd0);
    check_val("rst_sel_b", {30'd0, sel_b}, 32'd0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_cnt", cnt, 32'd0);
    rst = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    check_val("exmem_stall", {31'd0, stall}, 32'd0);
    tick();
    check_val("exmem_a", {30'd0, sel_a}, 32'd1);
    check_val("exmem_b", {30'd0, sel_b}, 32'd0);
    nop(); tick(); tick();

    // add $3 ; nop ; or $6,$7,$3
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    nop(); tick();
    issue(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    check_val("memwb_a", {30'd0, sel_a}, 32'd0);
    check_val("memwb_b", {30'd0, sel_b}, 32'd2);
    nop(); tick(); tick();

    // add $3 ; add $3 ; and $8,$3,$3
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); tick();
    check_val("newest_a", {30'd0, sel_a}, 32'd1);
    check_val("newest_b", {30'd0, sel_b}, 32'd1);
    nop(); tick(); tick();

    // lw $2,0($1) ; add $4,$2,$2
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); tick();
    issue(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    check_val("lu_stall", {31'd0, stall}, 32'd1);
    check_val("lu_cnt_before", cnt, 32'd0);
    tick(); exp_cnt++;
    check_val("lu_bubble_a", {30'd0, sel_a}, 32'd0);
    check_val("lu_bubble_b", {30'd0, sel_b}, 32'd0);
    check_val("lu_stall_once", {31'd0, stall}, 32'd0);
    check_val("lu_cnt_after", cnt, exp_cnt);
    tick();
    check_val("lu_fwd_a", {30'd0, sel_a}, 32'd2);
    check_val("lu_fwd_b", {30'd0, sel_b}, 32'd2);
    nop(); tick(); tick();

    // lw $0 ; reader of $0 ; add $0 ; reader of $0
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); tick();
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    check_val("r0_lw_stall", {31'd0, stall}, 32'd0);
    tick();
    check_val("r0_lw_a", {30'd0, sel_a}, 32'd0);
    check_val("r0_lw_b", {30'd0, sel_b}, 32'd0);
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); tick();
    check_val("r0_add_a", {30'd0, sel_a}, 32'd0);
    check_val("r0_add_b", {30'd0, sel_b}, 32'd0);
    nop(); tick(); tick();

    // lw $5 ; reader of $5 with flush in the hazard cycle
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); tick();
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
    check_val("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    check_val("flush_cnt", cnt, exp_cnt);
    check_val("flush_a", {30'd0, sel_a}, 32'd0);
    nop(); tick(); tick();

    // lw $6 ; reader of $6, reset during the stall cycle
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0); tick();
    issue(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    check_val("rs_stall_pre", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; exp_cnt = 0;
    check_val("rs_stall", {31'd0, stall}, 32'd0);
    check_val("rs_a", {30'd0, sel_a}, 32'd0);
    check_val("rs_b", {30'd0, sel_b}, 32'd0);
    check_val("rs_cnt", cnt, 32'd0);
    tick();
    check_val("rs_tags_empty_a", {30'd0, sel_a}, 32'd0);
    check_val("rs_tags_empty_b", {30'd0, sel_b}, 32'd0);
    nop(); tick(); tick();

    // Four load-use pairs: 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); tick();
      issue(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      check_val("sat_stall", {31'd0, sat_stall}, 32'd1);
      tick(); exp_cnt++;
      tick();
      check_val("sat_fwd_b", {30'd0, sat_sel_b}, 32'd2);
      if (i == 2) check_val("sat_cnt_3", {30'd0, sat_cnt}, 32'd3);
    end
    check_val("sat_cnt_hold", {30'd0, sat_cnt}, 32'd3);
    check_val("wide_cnt_4", cnt, exp_cnt);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
